// File: rtl/layer_scheduler_pkg.sv
// rtl/layer_scheduler_pkg.sv - shared fixed-point types and constants for the layer scheduler
package layer_scheduler_pkg;

  localparam int INTEGER_WIDTH  = 8;
  localparam int FRACTION_WIDTH = 8;
  localparam int CLOCK_PERIOD   = 10;
  localparam int RESET_PERIOD   = 30;

  typedef logic signed [INTEGER_WIDTH-1:-FRACTION_WIDTH] fixed_t;

  typedef enum logic [1:0] {
    ACT_NONE,
    ACT_RELU,
    ACT_SIGMOID
  } activation_type;

  // Neuron select width; a single-neuron layer still carries a 1-bit index.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/layer_scheduler_if.sv
// rtl/layer_scheduler_if.sv - handshake between the scheduler and the shared neuron datapath
interface layer_scheduler_if #(
  parameter int IDX_W = 4
);

  logic                         neuron_go;
  logic [IDX_W-1:0]             neuron_index;
  logic                         neuron_done;
  layer_scheduler_pkg::fixed_t  neuron_out;

  // The scheduler drives go/index and consumes the neuron result.
  modport master (
    output neuron_go,
    output neuron_index,
    input  neuron_done,
    input  neuron_out
  );

  // The shared neuron sees go/index and returns done/result.
  modport slave (
    input  neuron_go,
    input  neuron_index,
    output neuron_done,
    output neuron_out
  );

endinterface

// File: rtl/layer_scheduler.sv
// rtl/layer_scheduler.sv - time-multiplexes one shared neuron over a layer; LAYER_SCHEDULER_TIMEOUT_EN adds a WAIT watchdog
module layer_scheduler
  import layer_scheduler_pkg::*;
#(
  parameter int NUM_NEURONS = 10
`ifdef LAYER_SCHEDULER_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 512
`endif
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              inputs_ready,
  layer_scheduler_if.master nif,
  output fixed_t            outputs [NUM_NEURONS],
  output logic              output_ready,
  output logic              busy
`ifdef LAYER_SCHEDULER_TIMEOUT_EN
  ,
  output logic              timeout_err
`endif
);

  localparam int               IDX_W      = idx_width(NUM_NEURONS);
  localparam logic [IDX_W-1:0] LAST_INDEX = IDX_W'(NUM_NEURONS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT,
    STORE,
    DONE
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] index;
  logic             go;

`ifdef LAYER_SCHEDULER_TIMEOUT_EN
  localparam int               WCNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(TIMEOUT_CYCLES - 1);
  logic [WCNT_W-1:0] wait_count;
`endif

  assign nif.neuron_go    = go;
  assign nif.neuron_index = index;

  // Layer sequencer: go is low only in START, so a stale done from the previous
  // neuron is never sampled and the neuron sees exactly one low cycle per neuron.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      index        <= '0;
      go           <= 1'b0;
      output_ready <= 1'b0;
      busy         <= 1'b0;
      for (int i = 0; i < NUM_NEURONS; i++) outputs[i] <= '0;
`ifdef LAYER_SCHEDULER_TIMEOUT_EN
      timeout_err  <= 1'b0;
      wait_count   <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (inputs_ready) begin
            state <= START;
            index <= '0;
            busy  <= 1'b1;
`ifdef LAYER_SCHEDULER_TIMEOUT_EN
            timeout_err <= 1'b0;
`endif
          end
        end
        START: begin
          go    <= 1'b1;
          state <= WAIT;
`ifdef LAYER_SCHEDULER_TIMEOUT_EN
          wait_count <= '0;
`endif
        end
        WAIT: begin
          if (nif.neuron_done) begin
            outputs[index] <= nif.neuron_out;
            state          <= STORE;
`ifdef LAYER_SCHEDULER_TIMEOUT_EN
          end else if (wait_count == WCNT_LAST) begin
            outputs[index] <= '0;
            timeout_err    <= 1'b1;
            state          <= STORE;
          end else begin
            wait_count <= wait_count + 1'b1;
`endif
          end
        end
        STORE: begin
          go <= 1'b0;
          if (index == LAST_INDEX) begin
            state        <= DONE;
            busy         <= 1'b0;
            output_ready <= 1'b1;
          end else begin
            index <= index + 1'b1;
            state <= START;
          end
        end
        DONE: begin
          if (!inputs_ready) begin
            state        <= IDLE;
            output_ready <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
